// File: rtl/rvx_dest_select_slice_pkg.sv
// Shared definitions for destination-select routers: error counter width and the
// binary-ID to select-mask decoder reused by sibling routers.
package rvx_dest_select_slice_pkg;

    localparam int RVX_DSS_ERRCNT_WIDTH = 8;
    localparam int DSS_MAX_TARGET       = 32;

    typedef struct packed {
        logic                      bad;
        logic [DSS_MAX_TARGET-1:0] sel;
    } dss_dec_t;

    // One-hot for in-range IDs; all-ones ID beyond the target range broadcasts when enabled.
    function automatic dss_dec_t dss_decode(
        input logic [DSS_MAX_TARGET-1:0] id,
        input int                        id_width,
        input int                        num_target,
        input logic                      bcast_en
    );
        dss_dec_t                  res;
        logic [DSS_MAX_TARGET-1:0] all_ones_id;
        res.bad     = 1'b0;
        res.sel     = '0;
        all_ones_id = (DSS_MAX_TARGET'(1) << id_width) - DSS_MAX_TARGET'(1);
        if (id < DSS_MAX_TARGET'(num_target)) begin
            res.sel[id[4:0]] = 1'b1;
        end else if (bcast_en && (id == all_ones_id)) begin
            res.sel = (DSS_MAX_TARGET'(1) << num_target) - DSS_MAX_TARGET'(1);
        end else begin
            res.bad = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/rvx_dest_select_slice_if.sv
// Upstream/downstream valid-ready bundle of the destination-select slice.
// slave = the slice's view, master = the environment driving and consuming it.
interface rvx_dest_select_slice_if #(
    parameter int NUM_TARGET = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2
);
    logic                  s_valid;
    logic                  s_ready;
    logic [ID_WIDTH-1:0]   s_dest;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [NUM_TARGET-1:0] m_select;
    logic [DATA_WIDTH-1:0] m_data;

    modport slave (
        input  s_valid, s_dest, s_data, m_ready,
        output s_ready, m_valid, m_select, m_data
    );

    modport master (
        output s_valid, s_dest, s_data, m_ready,
        input  s_ready, m_valid, m_select, m_data
    );
endinterface

// File: rtl/rvx_skid_slice.sv
// Two-entry valid/ready skid buffer: main register drives the output, skid register
// catches the one beat accepted while main is stalled, so o_ready is purely registered.
module rvx_skid_slice #(
    parameter int WIDTH = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);
    logic             r_main_vld;
    logic [WIDTH-1:0] r_main_data;
    logic             r_skid_vld;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_ready;
    logic             w_acc;
    logic             w_take;
    logic             w_skid_vld_nxt;

    always_comb begin
        w_acc          = i_valid & r_ready;
        // Main is free when empty or being drained this cycle.
        w_take         = ~r_main_vld | i_ready;
        w_skid_vld_nxt = r_skid_vld;
        if (w_take) begin
            w_skid_vld_nxt = 1'b0;
        end else if (w_acc) begin
            w_skid_vld_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_vld  <= 1'b0;
            r_main_data <= '0;
            r_skid_vld  <= 1'b0;
            r_skid_data <= '0;
            r_ready     <= 1'b0;
        end else begin
            r_ready    <= ~w_skid_vld_nxt;
            r_skid_vld <= w_skid_vld_nxt;
            if (w_take) begin
                // A full skid is always older than anything upstream, so it goes first.
                if (r_skid_vld) begin
                    r_main_vld  <= 1'b1;
                    r_main_data <= r_skid_data;
                end else begin
                    r_main_vld <= w_acc;
                    if (w_acc) begin
                        r_main_data <= i_data;
                    end
                end
            end else if (w_acc) begin
                r_skid_data <= i_data;
            end
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_main_vld;
    assign o_data  = r_main_data;

endmodule

// File: rtl/rvx_dest_select_slice.sv
// Registered destination decoder ahead of the 1-to-N fan-out: decodes the binary ID to a
// select mask, buffers payload+mask in a skid slice, and drops/counts bad-ID transfers.
module rvx_dest_select_slice
    import rvx_dest_select_slice_pkg::*;
#(
    parameter int NUM_TARGET = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2,
    parameter int BCAST_EN   = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    rvx_dest_select_slice_if.slave          io,
    output logic                            err_pulse,
    output logic [RVX_DSS_ERRCNT_WIDTH-1:0] err_count,
    input  logic                            err_clear
);
    localparam int PW = NUM_TARGET + DATA_WIDTH;
    localparam logic [DSS_MAX_TARGET-1:0] C_SEL_MASK =
        (DSS_MAX_TARGET'(1) << NUM_TARGET) - DSS_MAX_TARGET'(1);

    if ((2 ** ID_WIDTH) < NUM_TARGET) begin : g_chk_id_width
        $error("rvx_dest_select_slice: ID_WIDTH too small to address NUM_TARGET targets");
    end
    if (NUM_TARGET > DSS_MAX_TARGET) begin : g_chk_num_target
        $error("rvx_dest_select_slice: NUM_TARGET exceeds decoder capacity");
    end

    dss_dec_t                        w_dec;
    logic                            w_bad;
    logic [NUM_TARGET-1:0]           w_sel;
    logic                            w_s_ready;
    logic                            w_good_valid;
    logic                            w_bad_acc;
    logic [PW-1:0]                   w_out;
    logic                            r_err_pulse;
    logic [RVX_DSS_ERRCNT_WIDTH-1:0] r_err_count;

    assign w_dec = dss_decode(DSS_MAX_TARGET'(io.s_dest), ID_WIDTH, NUM_TARGET, BCAST_EN != 0);
    // Any decoded bit outside the target range is treated as bad, so an empty mask can never leak out.
    assign w_bad        = w_dec.bad | (|(w_dec.sel & ~C_SEL_MASK));
    assign w_sel        = w_dec.sel[NUM_TARGET-1:0];
    assign w_good_valid = io.s_valid & ~w_bad;
    assign w_bad_acc    = io.s_valid & w_s_ready & w_bad;

    rvx_skid_slice #(
        .WIDTH (PW)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_good_valid),
        .o_ready (w_s_ready),
        .i_data  ({w_sel, io.s_data}),
        .o_valid (io.m_valid),
        .i_ready (io.m_ready),
        .o_data  (w_out)
    );

    assign io.s_ready  = w_s_ready;
    assign io.m_select = w_out[PW-1 -: NUM_TARGET];
    assign io.m_data   = w_out[DATA_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err_pulse <= w_bad_acc;
            if (err_clear) begin
                r_err_count <= '0;
            end else if (w_bad_acc && (r_err_count != '1)) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_rvx_dest_select_slice.sv
// Directed and scoreboard bench for rvx_dest_select_slice with three configurations:
// A = 4 targets, B = 3 targets without broadcast, C = 3 targets with broadcast.
module tb_rvx_dest_select_slice;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rvx_dest_select_slice_if #(.NUM_TARGET(4), .DATA_WIDTH(32), .ID_WIDTH(2)) ifa ();
    rvx_dest_select_slice_if #(.NUM_TARGET(3), .DATA_WIDTH(32), .ID_WIDTH(2)) ifb ();
    rvx_dest_select_slice_if #(.NUM_TARGET(3), .DATA_WIDTH(32), .ID_WIDTH(2)) ifc ();

    logic       err_pulse_a, err_pulse_b, err_pulse_c;
    logic [7:0] err_count_a, err_count_b, err_count_c;
    logic       err_clear_a, err_clear_b, err_clear_c;

    rvx_dest_select_slice #(.NUM_TARGET(4), .DATA_WIDTH(32), .ID_WIDTH(2), .BCAST_EN(0)) dut_a (
        .clk(clk), .rst(rst), .io(ifa), .err_pulse(err_pulse_a), .err_count(err_count_a), .err_clear(err_clear_a));
    rvx_dest_select_slice #(.NUM_TARGET(3), .DATA_WIDTH(32), .ID_WIDTH(2), .BCAST_EN(0)) dut_b (
        .clk(clk), .rst(rst), .io(ifb), .err_pulse(err_pulse_b), .err_count(err_count_b), .err_clear(err_clear_b));
    rvx_dest_select_slice #(.NUM_TARGET(3), .DATA_WIDTH(32), .ID_WIDTH(2), .BCAST_EN(1)) dut_c (
        .clk(clk), .rst(rst), .io(ifc), .err_pulse(err_pulse_c), .err_count(err_count_c), .err_clear(err_clear_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifa.s_valid = 0; ifa.s_dest = 0; ifa.s_data = 0; ifa.m_ready = 0;
        ifb.s_valid = 0; ifb.s_dest = 0; ifb.s_data = 0; ifb.m_ready = 0;
        ifc.s_valid = 0; ifc.s_dest = 0; ifc.s_data = 0; ifc.m_ready = 0;
        err_clear_a = 0; err_clear_b = 0; err_clear_c = 0;
        tick(); tick();
        total++; if (ifa.m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid: got %b want 0", ifa.m_valid); end
        total++; if (ifa.m_select !== 4'b0000) begin bad++; $display("FAIL reset_m_select: got %b want 0000", ifa.m_select); end
        total++; if (ifa.m_data !== 32'h0) begin bad++; $display("FAIL reset_m_data: got %h want 0", ifa.m_data); end
        total++; if (ifa.s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready: got %b want 0", ifa.s_ready); end
        total++; if (err_count_a !== 8'd0 || err_pulse_a !== 1'b0) begin bad++; $display("FAIL reset_err: got cnt=%0d pulse=%b want 0/0", err_count_a, err_pulse_a); end
        rst = 1'b0;
        #2;
        total++; if (ifa.s_ready !== 1'b0) begin bad++; $display("FAIL reset_release_s_ready_early: got %b want 0", ifa.s_ready); end
        tick();
        total++; if (ifa.s_ready !== 1'b1) begin bad++; $display("FAIL reset_release_s_ready: got %b want 1", ifa.s_ready); end
        total++; if (ifb.s_ready !== 1'b1 || ifc.s_ready !== 1'b1) begin bad++; $display("FAIL reset_release_bc: got %b%b want 11", ifb.s_ready, ifc.s_ready); end
    endtask

    task automatic test_stream();
        logic [3:0] sel_tab [4];
        sel_tab[0] = 4'b0001; sel_tab[1] = 4'b0010; sel_tab[2] = 4'b0100; sel_tab[3] = 4'b1000;
        ifa.m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ifa.s_valid = 1'b1;
            ifa.s_dest  = 2'(i % 4);
            ifa.s_data  = 32'h100 + 32'(i);
            tick();
            total++;
            if (ifa.m_valid !== 1'b1 || ifa.m_select !== sel_tab[i % 4] || ifa.m_data !== 32'h100 + 32'(i) || ifa.s_ready !== 1'b1) begin
                bad++;
                $display("FAIL stream_beat%0d: got v=%b sel=%b data=%h rdy=%b want v=1 sel=%b data=%h rdy=1",
                         i, ifa.m_valid, ifa.m_select, ifa.m_data, ifa.s_ready, sel_tab[i % 4], 32'h100 + 32'(i));
            end
        end
        ifa.s_valid = 1'b0;
        tick();
        total++; if (ifa.m_valid !== 1'b0) begin bad++; $display("FAIL stream_end_m_valid: got %b want 0", ifa.m_valid); end
    endtask

    task automatic test_backpressure();
        ifa.m_ready = 1'b1; ifa.s_valid = 1'b1; ifa.s_dest = 2'd1; ifa.s_data = 32'h200;
        tick();
        total++; if (ifa.m_data !== 32'h200 || ifa.m_valid !== 1'b1) begin bad++; $display("FAIL bp_b0: got v=%b data=%h want v=1 data=00000200", ifa.m_valid, ifa.m_data); end
        ifa.m_ready = 1'b0; ifa.s_dest = 2'd2; ifa.s_data = 32'h201;
        tick();
        total++; if (ifa.s_ready !== 1'b0) begin bad++; $display("FAIL bp_s_ready_drop: got %b want 0", ifa.s_ready); end
        total++; if (ifa.m_data !== 32'h200 || ifa.m_valid !== 1'b1) begin bad++; $display("FAIL bp_hold1: got v=%b data=%h want v=1 data=00000200", ifa.m_valid, ifa.m_data); end
        ifa.s_dest = 2'd3; ifa.s_data = 32'h202;
        tick();
        total++; if (ifa.s_ready !== 1'b0 || ifa.m_data !== 32'h200) begin bad++; $display("FAIL bp_hold2: got rdy=%b data=%h want rdy=0 data=00000200", ifa.s_ready, ifa.m_data); end
        tick();
        total++; if (ifa.m_select !== 4'b0010 || ifa.m_data !== 32'h200) begin bad++; $display("FAIL bp_hold3: got sel=%b data=%h want sel=0010 data=00000200", ifa.m_select, ifa.m_data); end
        ifa.m_ready = 1'b1;
        tick();
        total++; if (ifa.m_select !== 4'b0100 || ifa.m_data !== 32'h201 || ifa.s_ready !== 1'b1) begin bad++; $display("FAIL bp_release_b1: got sel=%b data=%h rdy=%b want sel=0100 data=00000201 rdy=1", ifa.m_select, ifa.m_data, ifa.s_ready); end
        tick();
        total++; if (ifa.m_select !== 4'b1000 || ifa.m_data !== 32'h202 || ifa.m_valid !== 1'b1) begin bad++; $display("FAIL bp_release_b2: got v=%b sel=%b data=%h want v=1 sel=1000 data=00000202", ifa.m_valid, ifa.m_select, ifa.m_data); end
        ifa.s_valid = 1'b0;
        tick();
        total++; if (ifa.m_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup: got %b want 0", ifa.m_valid); end
    endtask

    task automatic test_reset_mid();
        ifa.m_ready = 1'b0; ifa.s_valid = 1'b1; ifa.s_dest = 2'd0; ifa.s_data = 32'h300;
        tick();
        ifa.s_dest = 2'd3; ifa.s_data = 32'h301;
        tick();
        ifa.s_valid = 1'b0;
        total++; if (ifa.s_ready !== 1'b0 || ifa.m_valid !== 1'b1) begin bad++; $display("FAIL rstmid_full: got rdy=%b v=%b want 0/1", ifa.s_ready, ifa.m_valid); end
        #2 rst = 1'b1;
        #1;
        total++; if (ifa.m_valid !== 1'b0 || ifa.s_ready !== 1'b0 || ifa.m_data !== 32'h0 || ifa.m_select !== 4'b0) begin
            bad++; $display("FAIL rstmid_async: got v=%b rdy=%b sel=%b data=%h want 0/0/0000/0", ifa.m_valid, ifa.s_ready, ifa.m_select, ifa.m_data);
        end
        tick(); tick();
        rst = 1'b0;
        ifa.m_ready = 1'b1;
        tick();
        total++; if (ifa.s_ready !== 1'b1 || ifa.m_valid !== 1'b0 || ifa.m_data !== 32'h0) begin bad++; $display("FAIL rstmid_release: got rdy=%b v=%b data=%h want 1/0/0", ifa.s_ready, ifa.m_valid, ifa.m_data); end
        tick();
        total++; if (ifa.m_valid !== 1'b0) begin bad++; $display("FAIL rstmid_no_stale: got %b want 0", ifa.m_valid); end
    endtask

    task automatic test_bad_id();
        ifb.m_ready = 1'b1; ifb.s_valid = 1'b1; ifb.s_dest = 2'd3; ifb.s_data = 32'hDEAD;
        total++; if (ifb.s_ready !== 1'b1) begin bad++; $display("FAIL badid_s_ready: got %b want 1", ifb.s_ready); end
        tick();
        ifb.s_valid = 1'b0;
        total++; if (err_pulse_b !== 1'b1 || err_count_b !== 8'd1 || ifb.m_valid !== 1'b0) begin bad++; $display("FAIL badid_first: got pulse=%b cnt=%0d v=%b want 1/1/0", err_pulse_b, err_count_b, ifb.m_valid); end
        tick();
        total++; if (err_pulse_b !== 1'b0 || err_count_b !== 8'd1) begin bad++; $display("FAIL badid_pulse_width: got pulse=%b cnt=%0d want 0/1", err_pulse_b, err_count_b); end
        ifb.s_valid = 1'b1;
        repeat (100) tick();
        total++; if (err_count_b !== 8'd101) begin bad++; $display("FAIL badid_cnt101: got %0d want 101", err_count_b); end
        repeat (200) tick();
        ifb.s_valid = 1'b0;
        tick();
        total++; if (err_count_b !== 8'd255 || ifb.m_valid !== 1'b0) begin bad++; $display("FAIL badid_saturate: got cnt=%0d v=%b want 255/0", err_count_b, ifb.m_valid); end
    endtask

    task automatic test_err_clear();
        ifb.s_valid = 1'b1; ifb.s_dest = 2'd3; err_clear_b = 1'b1;
        tick();
        ifb.s_valid = 1'b0; err_clear_b = 1'b0;
        total++; if (err_count_b !== 8'd0) begin bad++; $display("FAIL errclear_coincident: got %0d want 0", err_count_b); end
        ifb.s_valid = 1'b1;
        tick();
        ifb.s_valid = 1'b0;
        total++; if (err_count_b !== 8'd1) begin bad++; $display("FAIL errclear_recount: got %0d want 1", err_count_b); end
    endtask

    task automatic test_bcast();
        ifc.m_ready = 1'b0; ifc.s_valid = 1'b1; ifc.s_dest = 2'd3; ifc.s_data = 32'hA5;
        tick();
        ifc.s_dest = 2'd1; ifc.s_data = 32'h5A;
        total++; if (ifc.m_valid !== 1'b1 || ifc.m_select !== 3'b111 || ifc.m_data !== 32'hA5 || err_pulse_c !== 1'b0) begin
            bad++; $display("FAIL bcast_out: got v=%b sel=%b data=%h pulse=%b want 1/111/000000a5/0", ifc.m_valid, ifc.m_select, ifc.m_data, err_pulse_c);
        end
        tick();
        ifc.s_valid = 1'b0; ifc.m_ready = 1'b1;
        tick();
        total++; if (ifc.m_select !== 3'b010 || ifc.m_data !== 32'h5A || err_count_c !== 8'd0) begin
            bad++; $display("FAIL bcast_next: got sel=%b data=%h cnt=%0d want 010/0000005a/0", ifc.m_select, ifc.m_data, err_count_c);
        end
        tick();
        total++; if (ifc.m_valid !== 1'b0) begin bad++; $display("FAIL bcast_drain: got %b want 0", ifc.m_valid); end
    endtask

    task automatic test_random();
        logic [34:0] q[$];
        logic [34:0] exp;
        int          n_in   = 0;
        int          cycles = 0;
        int          errs   = 0;
        while (n_in < 10000 && cycles < 60000) begin
            ifb.s_valid = ($urandom_range(0, 3) != 0);
            ifb.s_dest  = 2'($urandom_range(0, 3));
            ifb.s_data  = $urandom;
            ifb.m_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (ifb.s_valid && ifb.s_ready) begin
                n_in++;
                if (ifb.s_dest < 2'd3) q.push_back({3'b001 << ifb.s_dest, ifb.s_data});
            end
            if (ifb.m_valid && ifb.m_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++; errs++;
                    if (errs < 10) $display("FAIL rand_extra_beat: got sel=%b data=%h want none", ifb.m_select, ifb.m_data);
                end else begin
                    exp = q.pop_front();
                    if ({ifb.m_select, ifb.m_data} !== exp) begin
                        bad++; errs++;
                        if (errs < 10) $display("FAIL rand_beat: got sel=%b data=%h want sel=%b data=%h", ifb.m_select, ifb.m_data, exp[34:32], exp[31:0]);
                    end
                end
            end
            tick();
            cycles++;
        end
        total++; if (n_in < 10000) begin bad++; $display("FAIL rand_timeout: got %0d beats want 10000", n_in); end
        ifb.s_valid = 1'b0; ifb.m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (ifb.m_valid) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL rand_drain_extra: got data=%h want none", ifb.m_data);
                end else begin
                    exp = q.pop_front();
                    if ({ifb.m_select, ifb.m_data} !== exp) begin
                        bad++; $display("FAIL rand_drain: got sel=%b data=%h want sel=%b data=%h", ifb.m_select, ifb.m_data, exp[34:32], exp[31:0]);
                    end
                end
            end
            tick();
        end
        total++; if (q.size() != 0) begin bad++; $display("FAIL rand_lost: got %0d undelivered want 0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_reset_mid();
        test_bad_id();
        test_err_clear();
        test_bcast();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
